// File: rtl/aud_pkg.sv
// Shared types and constants for the audio playback scheduler.
// Read side of the 512x32 audio FIFO, clocked by the WM8978 bit clock.
package aud_pkg;

    localparam int FIFO_DEPTH = 512;
    localparam int LVL_W      = 9;
    localparam int SMP_W      = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PREFILL = 2'd1,
        PLAY    = 2'd2,
        SKIP    = 2'd3
    } play_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: increments on inc, sticks at all-ones.
// Cleared only by the asynchronous reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && count != '1) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/audio_play_sched.sv
// Playback scheduler: prefill gating, underrun recovery and single-sample
// drift correction (drop/repeat) between the audio FIFO and the I2S DAC.
module audio_play_sched
    import aud_pkg::*;
#(
    parameter int START_LVL = 256,
    parameter int HIGH_LVL  = 448,
    parameter int LOW_LVL   = 64,
    parameter int CORR_GAP  = 1024,
    parameter int CNT_W     = 16
) (
    input  logic             aud_bclk,
    input  logic             rst,
    input  logic             play_en,
    input  logic             aud_dac_req,
    input  logic [LVL_W-1:0] fifo_rdusedw,
    input  logic             fifo_rdempty,
    input  logic [SMP_W-1:0] fifo_q,
    output logic             fifo_rdreq,
    output logic [SMP_W-1:0] dac_data,
    output logic             playing,
    output logic [CNT_W-1:0] underrun_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] rpt_cnt
);

    localparam int GAP_W = $clog2(CORR_GAP + 1);

    localparam logic [LVL_W-1:0] START_L = LVL_W'(START_LVL);
    localparam logic [LVL_W-1:0] HIGH_L  = LVL_W'(HIGH_LVL);
    localparam logic [LVL_W-1:0] LOW_L   = LVL_W'(LOW_LVL);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(CORR_GAP);

    play_state_t      state;
    logic             q_valid;
    logic [GAP_W-1:0] gap;

    logic gap_ok;
    logic drop_cond;
    logic rpt_cond;
    logic play_req;
    logic und_hit;
    logic drop_hit;
    logic rpt_hit;

    assign gap_ok    = gap >= GAP_MAX;
    assign drop_cond = (fifo_rdusedw >= HIGH_L) && gap_ok;
    assign rpt_cond  = (fifo_rdusedw <= LOW_L) && gap_ok;

    assign play_req = play_en && aud_dac_req && (state == PLAY);
    assign und_hit  = play_req && fifo_rdempty;
    assign drop_hit = play_req && !fifo_rdempty && drop_cond;
    assign rpt_hit  = play_req && !fifo_rdempty && !drop_cond && rpt_cond;

    // Normal reads and the first (discarded) drop read share the PLAY term.
    always_comb begin
        fifo_rdreq = 1'b0;
        if (play_req && !fifo_rdempty && !rpt_hit) begin
            fifo_rdreq = 1'b1;
        end
        if (play_en && state == SKIP && !fifo_rdempty) begin
            fifo_rdreq = 1'b1;
        end
    end

    always_ff @(posedge aud_bclk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            dac_data <= '0;
            playing  <= 1'b0;
            q_valid  <= 1'b0;
            gap      <= '0;
        end else if (!play_en) begin
            state    <= IDLE;
            dac_data <= '0;
            playing  <= 1'b0;
            q_valid  <= 1'b0;
        end else begin
            q_valid <= fifo_rdreq && !drop_hit;
            if (q_valid) begin
                dac_data <= fifo_q;
            end
            if (aud_dac_req && !gap_ok) begin
                gap <= gap + GAP_W'(1);
            end
            unique case (state)
                IDLE: begin
                    state    <= PREFILL;
                    dac_data <= '0;
                end
                PREFILL: begin
                    dac_data <= '0;
                    if (fifo_rdusedw >= START_L) begin
                        state   <= PLAY;
                        playing <= 1'b1;
                        gap     <= GAP_MAX;
                    end
                end
                PLAY: begin
                    if (und_hit) begin
                        state    <= PREFILL;
                        playing  <= 1'b0;
                        dac_data <= '0;
                    end else if (drop_hit) begin
                        state <= SKIP;
                        gap   <= '0;
                    end else if (rpt_hit) begin
                        gap <= '0;
                    end
                end
                SKIP: begin
                    state <= PLAY;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_und_cnt (
        .clk   (aud_bclk),
        .rst   (rst),
        .inc   (und_hit),
        .count (underrun_cnt)
    );

    sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clk   (aud_bclk),
        .rst   (rst),
        .inc   (drop_hit),
        .count (drop_cnt)
    );

    sat_counter #(.W(CNT_W)) u_rpt_cnt (
        .clk   (aud_bclk),
        .rst   (rst),
        .inc   (rpt_hit),
        .count (rpt_cnt)
    );

endmodule

// File: doc/audio_play_sched.md
Name: audio_play_sched

Overview:
Playback scheduler on the WM8978 bit-clock side of the Ethernet audio path. It owns the read port of the 512x32 async audio FIFO (non-show-ahead, 1-cycle read latency) and decides, per DAC sample request, whether to read, mute, skip or repeat.
- Gates playback until the FIFO is pre-filled.
- Recovers from underruns by muting and re-prefilling.
- Corrects slow Ethernet/audio clock drift by dropping or repeating single samples.
- Sits between the FIFO read side and the I2S DAC serializer.

Parameters:
START_LVL, 256, rdusedw threshold to leave PREFILL and start playback
HIGH_LVL, 448, rdusedw at or above which one sample is dropped (SKIP)
LOW_LVL, 64, rdusedw at or below which (while non-empty) one sample is repeated
CORR_GAP, 1024, minimum number of aud_dac_req pulses between two drift corrections
CNT_W, 16, width of status counters

Ports:
aud_bclk  in  1  WM8978 bit clock; sole clock
rst  in  1  asynchronous reset, active-high
play_en  in  1  playback enable (quasi-static, already synchronous to aud_bclk)
aud_dac_req  in  1  one-cycle pulse requesting the next 32-bit DAC sample
fifo_rdusedw  in  9  FIFO read-side fill level
fifo_rdempty  in  1  FIFO read-side empty
fifo_q  in  32  FIFO read data, valid one cycle after fifo_rdreq
fifo_rdreq  out  1  FIFO read request (combinational from state/inputs, never asserted when fifo_rdempty=1)
dac_data  out  32  registered sample to the DAC serializer
playing  out  1  high while in PLAY or SKIP
underrun_cnt  out  CNT_W  saturating count of underruns
drop_cnt  out  CNT_W  saturating count of dropped samples
rpt_cnt  out  CNT_W  saturating count of repeated samples

Behaviour:
- Reset (async, rst=1): state IDLE, dac_data=0, fifo_rdreq=0, playing=0, all counters=0, q_valid=0, gap counter=0.
- States: IDLE, PREFILL, PLAY, SKIP.
- IDLE: no reads, dac_data held at 0. play_en=1 -> PREFILL.
- PREFILL: no reads; dac_data=0 (mute). Requests are ignored. At fifo_rdusedw>=START_LVL -> PLAY on the next cycle, with the gap counter preset to CORR_GAP so a correction is allowed immediately.
- PLAY, on aud_dac_req, evaluated in priority order:
  1. fifo_rdempty=1: underrun. No read; dac_data<=0 next cycle; underrun_cnt++; -> PREFILL.
  2. rdusedw>=HIGH_LVL and gap>=CORR_GAP: fifo_rdreq=1; -> SKIP; gap<=0; drop_cnt++.
  3. rdusedw<=LOW_LVL and gap>=CORR_GAP: no read; dac_data keeps its previous value; gap<=0; rpt_cnt++.
  4. Otherwise: fifo_rdreq=1 (normal read).
- Gap counter increments on every aud_dac_req and saturates at CORR_GAP.
- SKIP lasts exactly one cycle. It issues fifo_rdreq=1 again if fifo_rdempty=0, then returns to PLAY. The q from the first read is discarded; the q from the second read becomes dac_data. If the FIFO is empty in SKIP, there is no second read and dac_data keeps the previous sample.
- Read pipeline: q_valid<=fifo_rdreq (excluding the discarded SKIP first read). When q_valid=1, dac_data<=fifo_q. Latency is aud_dac_req to dac_data update = 2 cycles (req/rdreq cycle, FIFO latch cycle, register).
- aud_dac_req arriving during SKIP is ignored and counted as neither a drop nor a repeat. System guarantee: requests are at least 64 cycles apart.
- play_en=0 in any state -> IDLE next cycle, dac_data<=0, and any in-flight q_valid is discarded. A read already issued is consumed from the FIFO but not output.
- Counters saturate at all-ones and are cleared only by rst.
- Simultaneous underrun and drift conditions cannot occur (empty implies rdusedw=0). Empty takes priority.

Decomposition:
- Shared package (aud_pkg): state encoding typedef (IDLE/PREFILL/PLAY/SKIP), FIFO depth constant 512, level width 9, sample width 32.
- One natural sub-module: sat_counter (CNT_W-wide, inc, saturating), instantiated three times.
- FSM and read pipeline stay in the top module.

Test Plan:
- Reset/prefill: play_en=1, rdusedw ramps 0->255 -> no rdreq, dac_data=0, playing=0. At 256 -> playing=1 next cycle.
- Normal play: rdusedw=300, req pulse, fifo_q=0x12345678 -> fifo_rdreq on the req cycle, dac_data=0x12345678 two cycles after req.
- Underrun: PLAY, fifo_rdempty=1 at req -> no rdreq, dac_data=0, underrun_cnt=1, state PREFILL, no reads until rdusedw>=256.
- Drop: rdusedw=450, q sequence A,B -> rdreq high for 2 consecutive cycles, dac_data=B, drop_cnt=1. A second req with rdusedw=450 within 1024 reqs -> single read only.
- Repeat: rdusedw=40, non-empty, previous dac_data=0xCAFEF00D -> no rdreq, dac_data stays 0xCAFEF00D, rpt_cnt=1.
- Mid-play disable: play_en dropped the cycle after rdreq -> dac_data=0, returned data not output, state IDLE. Async rst mid-SKIP -> all outputs 0 immediately.
